// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter that merges NUM_SRC AXI-Stream sources into one registered output.
// Each grant lasts for one burst. A burst ends on the source tlast or after MAX_BURST beats.
// Optional: define AXIS_ARB_TDEST_EN to add m00_axis_tdest, which carries the index of the
// source that produced each beat.
module axis_rr_arbiter #(
  parameter int unsigned DATA_SIZE = 32,
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned MAX_BURST = 16,
  localparam int unsigned StrbW    = DATA_SIZE / 8,
  localparam int unsigned IdxW     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
  localparam int unsigned CntW     = $clog2(MAX_BURST) + 1
) (
  input  logic                         axis_aclk,
  input  logic                         axis_areset,
  input  logic [NUM_SRC*DATA_SIZE-1:0] s_axis_tdata,
  input  logic [NUM_SRC*StrbW-1:0]     s_axis_tstrb,
  input  logic [NUM_SRC-1:0]           s_axis_tvalid,
  input  logic [NUM_SRC-1:0]           s_axis_tlast,
  output logic [NUM_SRC-1:0]           s_axis_tready,
  output logic [DATA_SIZE-1:0]         m00_axis_tdata,
  output logic [StrbW-1:0]             m00_axis_tstrb,
`ifdef AXIS_ARB_TDEST_EN
  output logic [IdxW-1:0]              m00_axis_tdest,
`endif
  output logic                         m00_axis_tvalid,
  output logic                         m00_axis_tlast,
  input  logic                         m00_axis_tready,
  output logic [NUM_SRC-1:0]           grant,
  output logic                         busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e               state_q, state_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [IdxW-1:0]      gidx_q, gidx_d;
  logic [IdxW-1:0]      last_q, last_d;
  logic [CntW-1:0]      cnt_q, cnt_d;

  logic [DATA_SIZE-1:0] tdata_q, tdata_d;
  logic [StrbW-1:0]     tstrb_q, tstrb_d;
  logic                 tvalid_q, tvalid_d;
  logic                 tlast_q, tlast_d;
`ifdef AXIS_ARB_TDEST_EN
  logic [IdxW-1:0]      tdest_q, tdest_d;
`endif

  logic                 win_found;
  logic [IdxW-1:0]      win_idx;
  int unsigned          cand;
  logic [IdxW-1:0]      cand_idx;

  logic                 out_ready;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_SIZE-1:0] sel_data;
  logic [StrbW-1:0]     sel_strb;
  logic                 accept;
  logic                 burst_end;

  // Rotating priority search: first valid source after the previous winner, with wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      cand     = (32'(last_q) + 32'd1 + i) % NUM_SRC;
      cand_idx = IdxW'(cand);
      if (!win_found && s_axis_tvalid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Granted-source mux and handshake qualification.
  always_comb begin
    out_ready = ~tvalid_q | m00_axis_tready;
    sel_valid = s_axis_tvalid[gidx_q];
    sel_last  = s_axis_tlast[gidx_q];
    sel_data  = s_axis_tdata[32'(gidx_q) * DATA_SIZE +: DATA_SIZE];
    sel_strb  = s_axis_tstrb[32'(gidx_q) * StrbW +: StrbW];
    accept    = (state_q == StGrant) & out_ready & sel_valid;
    // cnt_q counts beats already accepted, so MAX_BURST-1 marks the final allowed beat.
    burst_end = accept & (sel_last | (cnt_q == CntW'(MAX_BURST - 1)));
    s_axis_tready = ((state_q == StGrant) && out_ready) ? grant_q : '0;
  end

  // Arbitration FSM next-state: pick a winner in idle, count beats while granted.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d = StGrant;
          gidx_d  = win_idx;
          grant_d = NUM_SRC'(1) << win_idx;
        end
      end
      StGrant: begin
        if (accept) begin
          cnt_d = cnt_q + CntW'(1);
        end
        if (burst_end) begin
          state_d = StIdle;
          grant_d = '0;
          last_d  = gidx_q;
          cnt_d   = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output register: load on acceptance, otherwise drop valid once the beat drains.
  always_comb begin
    tdata_d  = tdata_q;
    tstrb_d  = tstrb_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
`ifdef AXIS_ARB_TDEST_EN
    tdest_d  = tdest_q;
`endif
    if (accept) begin
      tdata_d  = sel_data;
      tstrb_d  = sel_strb;
      tvalid_d = 1'b1;
      tlast_d  = burst_end;
`ifdef AXIS_ARB_TDEST_EN
      tdest_d  = gidx_q;
`endif
    end else if (tvalid_q && m00_axis_tready) begin
      tvalid_d = 1'b0;
    end
  end

  // State and datapath registers; reset drops any beat held in the output stage.
  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      gidx_q   <= '0;
      last_q   <= IdxW'(NUM_SRC - 1);
      cnt_q    <= '0;
      tdata_q  <= '0;
      tstrb_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
`ifdef AXIS_ARB_TDEST_EN
      tdest_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      gidx_q   <= gidx_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tstrb_q  <= tstrb_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
`ifdef AXIS_ARB_TDEST_EN
      tdest_q  <= tdest_d;
`endif
    end
  end

  assign m00_axis_tdata  = tdata_q;
  assign m00_axis_tstrb  = tstrb_q;
  assign m00_axis_tvalid = tvalid_q;
  assign m00_axis_tlast  = tlast_q;
`ifdef AXIS_ARB_TDEST_EN
  assign m00_axis_tdest  = tdest_q;
`endif
  assign grant           = grant_q;
  assign busy            = (state_q == StGrant);

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Self-checking bench for axis_rr_arbiter: a burst-level reference model plus directed tests.
module tb_axis_rr_arbiter;
  localparam int DW   = 32;
  localparam int NS   = 4;
  localparam int MAXB = 16;
  localparam int SW   = DW / 8;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    logic          l;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NS*DW-1:0] s_tdata = '0;
  logic [NS*SW-1:0] s_tstrb = '0;
  logic [NS-1:0]    s_tvalid = '0;
  logic [NS-1:0]    s_tlast = '0;
  logic [NS-1:0]    s_tready;
  logic [DW-1:0]    m_tdata;
  logic [SW-1:0]    m_tstrb;
  logic             m_tvalid;
  logic             m_tlast;
  logic             ds_ready = 1'b1;
  logic [NS-1:0]    grant;
  logic             busy;

  axis_rr_arbiter #(.DATA_SIZE(DW), .NUM_SRC(NS), .MAX_BURST(MAXB)) dut (
    .axis_aclk      (clk),
    .axis_areset    (rst),
    .s_axis_tdata   (s_tdata),
    .s_axis_tstrb   (s_tstrb),
    .s_axis_tvalid  (s_tvalid),
    .s_axis_tlast   (s_tlast),
    .s_axis_tready  (s_tready),
    .m00_axis_tdata (m_tdata),
    .m00_axis_tstrb (m_tstrb),
    .m00_axis_tvalid(m_tvalid),
    .m00_axis_tlast (m_tlast),
    .m00_axis_tready(ds_ready),
    .grant          (grant),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Stimulus: one beat queue per source; the front beat is presented while non-empty.
  beat_t srcq[NS][$];
  beat_t outlog[$];
  int    glog[$];

  // Reference model: whole-burst ownership plus a one-entry output holding slot.
  int            m_busy, m_g, m_last, m_cnt;
  logic          o_v, o_l;
  logic [DW-1:0] o_d;
  logic [SW-1:0] o_s;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_g = 0; m_last = NS - 1; m_cnt = 0;
      o_v = 1'b0; o_l = 1'b0; o_d = '0; o_s = '0;
    end else begin
      int    was_busy;
      int    can_take;
      beat_t b;
      was_busy = m_busy;
      can_take = m_busy != 0 && (!o_v || ds_ready) && s_tvalid[m_g];
      if (o_v && ds_ready) outlog.push_back('{d: o_d, s: o_s, l: o_l});
      if (can_take != 0) begin
        b = srcq[m_g].pop_front();
        o_v = 1'b1; o_d = b.d; o_s = b.s;
        o_l = b.l || (m_cnt == MAXB - 1);
        m_cnt++;
        if (o_l) begin
          m_busy = 0; m_last = m_g; m_cnt = 0;
        end
      end else if (o_v && ds_ready) begin
        o_v = 1'b0;
      end
      if (was_busy == 0 && s_tvalid != '0) begin
        for (int k = 1; k <= NS; k++) begin
          if (m_busy == 0 && s_tvalid[(m_last + k) % NS]) begin
            m_g = (m_last + k) % NS;
            m_busy = 1;
            glog.push_back(m_g);
          end
        end
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    logic [NS-1:0] g_exp, r_exp;
    g_exp = (m_busy != 0) ? NS'(1) << m_g : '0;
    r_exp = (m_busy != 0 && (!o_v || ds_ready)) ? g_exp : '0;
    chk("grant", 64'(grant), 64'(g_exp));
    chk("busy", 64'(busy), 64'(m_busy != 0));
    chk("s_tready", 64'(s_tready), 64'(r_exp));
    chk("m_tvalid", 64'(m_tvalid), 64'(o_v));
    if (o_v) begin
      chk("m_tdata", 64'(m_tdata), 64'(o_d));
      chk("m_tstrb", 64'(m_tstrb), 64'(o_s));
      chk("m_tlast", 64'(m_tlast), 64'(o_l));
    end
  end

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      if (srcq[i].size() > 0) begin
        s_tvalid[i]             = 1'b1;
        s_tdata[i*DW +: DW]     = srcq[i][0].d;
        s_tstrb[i*SW +: SW]     = srcq[i][0].s;
        s_tlast[i]              = srcq[i][0].l;
      end else begin
        s_tvalid[i]             = 1'b0;
        s_tdata[i*DW +: DW]     = '0;
        s_tstrb[i*SW +: SW]     = '0;
        s_tlast[i]              = 1'b0;
      end
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      drive_inputs();
    end
  endtask

  function automatic int pending();
    int p = 0;
    for (int i = 0; i < NS; i++) p += srcq[i].size();
    return p + int'(o_v) + m_busy;
  endfunction

  task automatic run_drain(input string name, input int budget);
    int c = 0;
    while (pending() != 0 && c < budget) begin
      tick(1);
      c++;
    end
    chk(name, 64'(c < budget), 64'd1);
    tick(2);
  endtask

  task automatic flush();
    for (int i = 0; i < NS; i++) srcq[i].delete();
    drive_inputs();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    flush();
    @(negedge clk);
    rst = 1'b0;
    tick(1);
  endtask

  task automatic push(input int src, input int data, input logic [SW-1:0] strb, input logic last);
    srcq[src].push_back('{d: DW'(data), s: strb, l: last});
  endtask

  initial begin
    int          exp3[16];
    logic [3:0]  pat;
    int          c;
    int          stall_seen;

    drive_inputs();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    tick(1);

    // All sources idle.
    tick(10);
    chk("idle_grant", 64'(grant), 64'd0);
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_tvalid", 64'(m_tvalid), 64'd0);
    chk("idle_tready", 64'(s_tready), 64'd0);

    // Sources 0 and 2, three beats each.
    outlog.delete(); glog.delete();
    foreach (exp3[i]) exp3[i] = 0;
    push(0, 1, 4'hF, 1'b0); push(0, 3, 4'hF, 1'b0); push(0, 9, 4'hF, 1'b1);
    push(2, 1, 4'hF, 1'b0); push(2, 3, 4'hF, 1'b0); push(2, 9, 4'hF, 1'b1);
    drive_inputs();
    run_drain("t2_timeout", 100);
    chk("t2_count", 64'(outlog.size()), 64'd6);
    if (outlog.size() == 6) begin
      exp3[0] = 1; exp3[1] = 3; exp3[2] = 9; exp3[3] = 1; exp3[4] = 3; exp3[5] = 9;
      for (int i = 0; i < 6; i++) begin
        chk("t2_data", 64'(outlog[i].d), 64'(exp3[i]));
        chk("t2_last", 64'(outlog[i].l), 64'(i == 2 || i == 5));
      end
    end
    chk("t2_glog_n", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) begin
      chk("t2_g0", 64'(glog[0]), 64'd0);
      chk("t2_g1", 64'(glog[1]), 64'd2);
    end

    // All four sources, two 2-beat bursts each, from a fresh reset.
    do_reset();
    outlog.delete(); glog.delete();
    for (int i = 0; i < NS; i++)
      for (int k = 0; k < 4; k++) push(i, 100 * i + k, 4'hF, k % 2 == 1);
    drive_inputs();
    run_drain("t3_timeout", 200);
    exp3 = '{0, 1, 100, 101, 200, 201, 300, 301, 2, 3, 102, 103, 202, 203, 302, 303};
    chk("t3_count", 64'(outlog.size()), 64'd16);
    if (outlog.size() == 16)
      for (int i = 0; i < 16; i++) chk("t3_data", 64'(outlog[i].d), 64'(exp3[i]));
    chk("t3_glog_n", 64'(glog.size()), 64'd8);
    if (glog.size() == 8)
      for (int i = 0; i < 8; i++) chk("t3_grant", 64'(glog[i]), 64'(i % 4));

    // Source 1 streams 20 beats with tlast only on the last; source 2 waits with one beat.
    outlog.delete(); glog.delete();
    for (int k = 0; k < 20; k++) push(1, 1000 + k, 4'hF, k == 19);
    push(2, 2000, 4'hF, 1'b1);
    drive_inputs();
    run_drain("t4_timeout", 200);
    chk("t4_count", 64'(outlog.size()), 64'd21);
    if (outlog.size() == 21) begin
      chk("t4_b15_last", 64'(outlog[14].l), 64'd0);
      chk("t4_b16_last", 64'(outlog[15].l), 64'd1);
      chk("t4_b16_data", 64'(outlog[15].d), 64'd1015);
      chk("t4_src2_data", 64'(outlog[16].d), 64'd2000);
      chk("t4_end_data", 64'(outlog[20].d), 64'd1019);
      chk("t4_end_last", 64'(outlog[20].l), 64'd1);
    end
    chk("t4_glog_n", 64'(glog.size()), 64'd3);
    if (glog.size() == 3) begin
      chk("t4_g0", 64'(glog[0]), 64'd1);
      chk("t4_g1", 64'(glog[1]), 64'd2);
      chk("t4_g2", 64'(glog[2]), 64'd1);
    end

    // Downstream ready toggles 1,0,0,1 during a 4-beat burst from source 0.
    outlog.delete(); glog.delete();
    for (int k = 0; k < 4; k++) push(0, 10 + k, 4'h5, k == 3);
    drive_inputs();
    pat = 4'b1001;
    c = 0;
    stall_seen = 0;
    while (pending() != 0 && c < 60) begin
      ds_ready = pat[c % 4];
      #1;
      if (!ds_ready && m_tvalid) begin
        chk("t5_stall_tready", 64'(s_tready), 64'd0);
        stall_seen++;
      end
      tick(1);
      c++;
    end
    ds_ready = 1'b1;
    chk("t5_timeout", 64'(c < 60), 64'd1);
    chk("t5_stalled", 64'(stall_seen > 0), 64'd1);
    tick(2);
    chk("t5_count", 64'(outlog.size()), 64'd4);
    if (outlog.size() == 4)
      for (int i = 0; i < 4; i++) begin
        chk("t5_data", 64'(outlog[i].d), 64'(10 + i));
        chk("t5_last", 64'(outlog[i].l), 64'(i == 3));
      end

    // Asynchronous reset mid-burst with a beat held in the output register.
    for (int k = 0; k < 8; k++) push(0, 50 + k, 4'hF, k == 7);
    drive_inputs();
    ds_ready = 1'b0;
    c = 0;
    while (!m_tvalid && c < 20) begin
      tick(1);
      c++;
    end
    chk("t6_loaded", 64'(m_tvalid), 64'd1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_tvalid", 64'(m_tvalid), 64'd0);
    chk("t6_tdata", 64'(m_tdata), 64'd0);
    chk("t6_tlast", 64'(m_tlast), 64'd0);
    chk("t6_grant", 64'(grant), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    chk("t6_tready", 64'(s_tready), 64'd0);
    flush();
    ds_ready = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(1);
    outlog.delete(); glog.delete();
    push(1, 77, 4'hF, 1'b1);
    push(0, 66, 4'hF, 1'b1);
    drive_inputs();
    run_drain("t6_timeout", 100);
    chk("t6_glog_n", 64'(glog.size()), 64'd2);
    if (glog.size() == 2) chk("t6_first", 64'(glog[0]), 64'd0);
    chk("t6_count", 64'(outlog.size()), 64'd2);
    if (outlog.size() == 2) begin
      chk("t6_d0", 64'(outlog[0].d), 64'd66);
      chk("t6_d1", 64'(outlog[1].d), 64'd77);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule
